// File: rtl/seven_seg_capture.sv
// Seven-segment display capture: samples a multiplexed, active-low
// segment/select bus, decodes each digit to hex, and assembles frames.
module seven_seg_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic [7:0]  Seven_segment_out,
  input  logic [3:0]  Seven_segment_sel,
  input  logic        err_clr,
  output logic [15:0] frame_data,
  output logic [3:0]  frame_dp,
  output logic        frame_valid,
  output logic        frame_stable,
  output logic        pattern_err,
  output logic        sel_err
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  // Synchronizer and change-detect registers
  logic [7:0] seg_s1_q, seg_s2_q, seg_prev_q;
  logic [3:0] sel_s1_q, sel_s2_q, sel_prev_q;
  logic       in_change;

  // FSM state and registered sample strobe
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          smp_q;
  logic [7:0]    smp_seg_q;
  logic [3:0]    smp_sel_q;

  // Decode results
  logic [6:0] pat;
  logic [3:0] dec_nib;
  logic       dec_ok;
  logic [3:0] sel_hit;
  logic       sel_blank;
  logic       sel_legal;
  logic [3:0] cap_hit;

  // Pending frame assembly
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  mask_q, mask_d;
  logic        frame_fire;

  // Output frame and stability tracking
  logic [15:0] frame_data_q;
  logic [3:0]  frame_dp_q;
  logic        frame_valid_q;
  logic        frame_stable_q;
  logic [2:0]  stab_q, stab_d;
  logic        frame_same;

  // Sticky error flags
  logic pattern_err_q, sel_err_q;
  logic perr_set, serr_set;

  // Two-flop synchronizers plus a one-cycle history for change detection
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      seg_prev_q <= '1;
      sel_s1_q   <= '1;
      sel_s2_q   <= '1;
      sel_prev_q <= '1;
    end else begin
      seg_s1_q   <= Seven_segment_out;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      sel_s1_q   <= Seven_segment_sel;
      sel_s2_q   <= sel_s1_q;
      sel_prev_q <= sel_s2_q;
    end
  end

  assign in_change = ({sel_s2_q, seg_s2_q} != {sel_prev_q, seg_prev_q});

  // Settle FSM: waits for a quiet bus, then issues one registered sample
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      smp_q     <= 1'b0;
      smp_seg_q <= '1;
      smp_sel_q <= '1;
    end else begin
      smp_q <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          if (in_change) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
          end
        end
        ST_SETTLE: begin
          if (in_change) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            smp_q     <= 1'b1;
            smp_seg_q <= seg_s2_q;
            smp_sel_q <= sel_s2_q;
            state_q   <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (in_change) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Segment pattern to hex nibble
  always_comb begin
    pat     = ~smp_seg_q[6:0];
    dec_ok  = 1'b1;
    dec_nib = '0;
    case (pat)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // One-cold select to one-hot digit position; blanking and multi-low are not legal
  always_comb begin
    sel_hit = '0;
    case (smp_sel_q)
      4'b1110: sel_hit = 4'b0001;
      4'b1101: sel_hit = 4'b0010;
      4'b1011: sel_hit = 4'b0100;
      4'b0111: sel_hit = 4'b1000;
      default: sel_hit = '0;
    endcase
    sel_blank = (smp_sel_q == 4'hF);
    sel_legal = |sel_hit;
    cap_hit   = smp_q ? sel_hit : 4'b0000;
  end

  assign frame_fire = (mask_q == 4'hF);

  // Pending digit/dp/mask update; a completed mask clears before the new capture is merged
  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    mask_d   = frame_fire ? 4'b0000 : mask_q;
    mask_d   = mask_d | cap_hit;
    for (int unsigned i = 0; i < 4; i++) begin
      if (cap_hit[i]) begin
        if (dec_ok) begin
          digits_d[i*4 +: 4] = dec_nib;
        end
        dp_d[i] = ~smp_seg_q[7];
      end
    end
  end

  // Pending frame registers
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      digits_q <= '0;
      dp_q     <= '0;
      mask_q   <= '0;
    end else begin
      digits_q <= digits_d;
      dp_q     <= dp_d;
      mask_q   <= mask_d;
    end
  end

  // Stable-run counter: saturates at 7, restarts at 1 on a changed frame
  always_comb begin
    frame_same = (digits_q == frame_data_q) && (dp_q == frame_dp_q);
    if (frame_same) begin
      stab_d = (stab_q == 3'd7) ? 3'd7 : stab_q + 3'd1;
    end else begin
      stab_d = 3'd1;
    end
  end

  // Frame publish: data, dp, valid pulse and stability level change together
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      frame_data_q   <= '0;
      frame_dp_q     <= '0;
      frame_valid_q  <= 1'b0;
      frame_stable_q <= 1'b0;
      stab_q         <= '0;
    end else begin
      frame_valid_q <= frame_fire;
      if (frame_fire) begin
        frame_data_q   <= digits_q;
        frame_dp_q     <= dp_q;
        stab_q         <= stab_d;
        frame_stable_q <= ({29'd0, stab_d} >= 32'(STABLE_FRAMES));
      end
    end
  end

  assign perr_set = smp_q && sel_legal && !dec_ok;
  assign serr_set = smp_q && !sel_legal && !sel_blank;

  // Sticky error flags; a same-cycle error event takes priority over the clear
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      pattern_err_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      if (perr_set) begin
        pattern_err_q <= 1'b1;
      end else if (err_clr) begin
        pattern_err_q <= 1'b0;
      end
      if (serr_set) begin
        sel_err_q <= 1'b1;
      end else if (err_clr) begin
        sel_err_q <= 1'b0;
      end
    end
  end

  assign frame_data   = frame_data_q;
  assign frame_dp     = frame_dp_q;
  assign frame_valid  = frame_valid_q;
  assign frame_stable = frame_stable_q;
  assign pattern_err  = pattern_err_q;
  assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: decoder vector table, directed multi-cycle
// sequences, and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        RESETn = 1'b0;
  logic [7:0]  Seven_segment_out = 8'hFF;
  logic [3:0]  Seven_segment_sel = 4'hF;
  logic        err_clr = 1'b0;
  logic [15:0] frame_data;
  logic [3:0]  frame_dp;
  logic        frame_valid;
  logic        frame_stable;
  logic        pattern_err;
  logic        sel_err;

  always #5 clk = ~clk;

  seven_seg_capture #(.SETTLE_CYCLES(16), .STABLE_FRAMES(4)) dut (
    .clk               (clk),
    .RESETn            (RESETn),
    .Seven_segment_out (Seven_segment_out),
    .Seven_segment_sel (Seven_segment_sel),
    .err_clr           (err_clr),
    .frame_data        (frame_data),
    .frame_dp          (frame_dp),
    .frame_valid       (frame_valid),
    .frame_stable      (frame_stable),
    .pattern_err       (pattern_err),
    .sel_err           (sel_err)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  // Segment sets {g,f,e,d,c,b,a} for hex 0..F.
  localparam logic [6:0] PATS [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        stable;
  } frame_t;

  frame_t      exp_q[$];
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  logic        m_perr, m_serr;
  logic [15:0] m_prev_data;
  logic [3:0]  m_prev_dp;
  int          m_run;
  int unsigned fv_count = 0;
  logic [3:0]  cur_sel = 4'hF;
  logic [7:0]  cur_seg = 8'hFF;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_dp = 4'h0; m_mask = 4'h0; m_perr = 1'b0; m_serr = 1'b0;
    m_prev_data = 16'h0; m_prev_dp = 4'h0; m_run = 0;
    exp_q.delete();
  endfunction

  // One settled digit presented on the bus.
  function automatic void model_sample(input logic [3:0] sel, input logic [7:0] seg);
    logic [3:0] lows;
    int n;
    int nib;
    frame_t f;
    lows = ~sel;
    if (lows == 4'h0) return;
    if ($countones(lows) != 1) begin
      m_serr = 1'b1;
      return;
    end
    n = 0;
    for (int i = 0; i < 4; i++) if (lows[i]) n = i;
    nib = -1;
    for (int k = 0; k < 16; k++) begin
      logic [6:0] inv;
      inv = ~seg[6:0];
      if (inv == PATS[k]) nib = k;
    end
    if (nib >= 0) m_dig[n] = 4'(nib);
    else m_perr = 1'b1;
    m_dp[n] = ~seg[7];
    m_mask[n] = 1'b1;
    if (m_mask == 4'hF) begin
      f.data = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      f.dp = m_dp;
      if (f.data == m_prev_data && f.dp == m_prev_dp) m_run = (m_run >= 7) ? 7 : m_run + 1;
      else m_run = 1;
      f.stable = (m_run >= 4);
      exp_q.push_back(f);
      m_prev_data = f.data;
      m_prev_dp = f.dp;
      m_mask = 4'h0;
    end
  endfunction

  // ---------------- frame monitor ----------------
  logic fv_prev = 1'b0;
  always @(negedge clk) begin
    if (!RESETn) begin
      fv_prev = 1'b0;
    end else begin
      if (fv_prev) chk("valid_one_cycle", {31'd0, frame_valid}, 32'd0);
      if (frame_valid) begin
        fv_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {16'd0, frame_data}, 32'hFFFF_FFFF);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          chk("frame_data", {16'd0, frame_data}, {16'd0, f.data});
          chk("frame_dp", {28'd0, frame_dp}, {28'd0, f.dp});
          chk("frame_stable", {31'd0, frame_stable}, {31'd0, f.stable});
        end
      end
      fv_prev = frame_valid;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic hold(input logic [3:0] sel, input logic [7:0] seg, input int n);
    Seven_segment_sel = sel;
    Seven_segment_out = seg;
    cur_sel = sel;
    cur_seg = seg;
    if (n >= 24) model_sample(sel, seg);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3, input int n);
    hold(4'b1110, d0, n);
    hold(4'b1101, d1, n);
    hold(4'b1011, d2, n);
    hold(4'b0111, d3, n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_perr = 1'b0;
    m_serr = 1'b0;
  endtask

  task automatic do_reset();
    chk("frames_pending_at_reset", exp_q.size(), 32'd0);
    RESETn = 1'b0;
    Seven_segment_sel = 4'hF;
    Seven_segment_out = 8'hFF;
    cur_sel = 4'hF;
    cur_seg = 8'hFF;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frame_data", {16'd0, frame_data}, 32'd0);
    chk("rst_frame_dp", {28'd0, frame_dp}, 32'd0);
    chk("rst_flags", {28'd0, frame_valid, frame_stable, pattern_err, sel_err}, 32'd0);
    @(posedge clk);
    #1;
    RESETn = 1'b1;
    model_reset();
    fv_prev = 1'b0;
  endtask

  // ---------------- decoder vector table ----------------
  typedef struct {
    logic [7:0] seg;
    logic [3:0] nib;
    logic       dp;
    logic       perr;
  } vec_t;

  vec_t vecs [19];

  initial begin
    int unsigned fv0;
    logic [3:0] rsel;
    logic [7:0] rseg;
    int rn;

    vecs[0]  = '{8'hC0, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{8'h79, 4'h1, 1'b1, 1'b0};
    vecs[2]  = '{8'hA4, 4'h2, 1'b0, 1'b0};
    vecs[3]  = '{8'hB0, 4'h3, 1'b0, 1'b0};
    vecs[4]  = '{8'h99, 4'h4, 1'b0, 1'b0};
    vecs[5]  = '{8'h12, 4'h5, 1'b1, 1'b0};
    vecs[6]  = '{8'h82, 4'h6, 1'b0, 1'b0};
    vecs[7]  = '{8'hF8, 4'h7, 1'b0, 1'b0};
    vecs[8]  = '{8'h80, 4'h8, 1'b0, 1'b0};
    vecs[9]  = '{8'h90, 4'h9, 1'b0, 1'b0};
    vecs[10] = '{8'h08, 4'hA, 1'b1, 1'b0};
    vecs[11] = '{8'h83, 4'hB, 1'b0, 1'b0};
    vecs[12] = '{8'hC6, 4'hC, 1'b0, 1'b0};
    vecs[13] = '{8'hA1, 4'hD, 1'b0, 1'b0};
    vecs[14] = '{8'h86, 4'hE, 1'b0, 1'b0};
    vecs[15] = '{8'h8E, 4'hF, 1'b0, 1'b0};
    vecs[16] = '{8'hFF, 4'hF, 1'b0, 1'b1};
    vecs[17] = '{8'hF7, 4'hF, 1'b0, 1'b1};
    vecs[18] = '{8'h40, 4'h0, 1'b1, 1'b0};

    model_reset();
    do_reset();

    for (int v = 0; v < 19; v++) begin
      fv0 = fv_count;
      scan(vecs[v].seg, 8'hF9, 8'hA4, 8'hB0, 40);
      chk($sformatf("vec%0d_frames", v), fv_count - fv0, 32'd1);
      chk($sformatf("vec%0d_nib", v), {28'd0, frame_data[3:0]}, {28'd0, vecs[v].nib});
      chk($sformatf("vec%0d_upper", v), {20'd0, frame_data[15:4]}, 32'h321);
      chk($sformatf("vec%0d_dp", v), {31'd0, frame_dp[0]}, {31'd0, vecs[v].dp});
      chk($sformatf("vec%0d_perr", v), {31'd0, pattern_err}, {31'd0, vecs[v].perr});
      clr();
    end

    // Basic scan, then repeated frames until stable, then a changed digit
    do_reset();
    fv0 = fv_count;
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 40);
    chk("scan_frames", fv_count - fv0, 32'd1);
    chk("scan_data", {16'd0, frame_data}, 32'h3210);
    chk("scan_dp", {28'd0, frame_dp}, 32'd0);
    chk("scan_errs", {30'd0, pattern_err, sel_err}, 32'd0);
    chk("scan_stable1", {31'd0, frame_stable}, 32'd0);
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 40);
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 40);
    chk("scan_stable3", {31'd0, frame_stable}, 32'd0);
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 40);
    chk("scan_stable4", {31'd0, frame_stable}, 32'd1);
    scan(8'hC0, 8'hF9, 8'h80, 8'hB0, 40);
    chk("changed_data", {16'd0, frame_data}, 32'h3810);
    chk("changed_stable", {31'd0, frame_stable}, 32'd0);

    // Digits held shorter than the settle window never capture
    fv0 = fv_count;
    for (int r = 0; r < 3; r++) scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 10);
    hold(4'hF, 8'hFF, 40);
    chk("short_hold_frames", fv_count - fv0, 32'd0);
    chk("short_hold_data", {16'd0, frame_data}, 32'h3810);

    // Bad pattern and illegal select stay sticky until cleared
    do_reset();
    hold(4'b1110, 8'hC0, 40);
    hold(4'b1101, 8'hFF, 40);
    hold(4'b1100, 8'hA4, 40);
    hold(4'b1011, 8'hA4, 40);
    hold(4'b0111, 8'hB0, 40);
    chk("err_frame_data", {16'd0, frame_data}, 32'h3200);
    chk("err_set", {30'd0, pattern_err, sel_err}, 32'd3);
    idle(20);
    chk("err_sticky", {30'd0, pattern_err, sel_err}, 32'd3);
    clr();
    chk("err_cleared", {30'd0, pattern_err, sel_err}, 32'd0);

    // Reset mid-frame discards partial captures
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 40);
    hold(4'b1110, 8'h99, 40);
    hold(4'b1101, 8'h92, 40);
    do_reset();
    fv0 = fv_count;
    hold(4'b1011, 8'hA4, 40);
    hold(4'b0111, 8'hB0, 40);
    chk("post_reset_partial", fv_count - fv0, 32'd0);
    hold(4'b1110, 8'hC0, 40);
    hold(4'b1101, 8'hF9, 40);
    chk("post_reset_frames", fv_count - fv0, 32'd1);
    chk("post_reset_data", {16'd0, frame_data}, 32'h3210);

    // Randomized run against the model
    do_reset();
    for (int it = 0; it < 80; it++) begin
      do begin
        case ($urandom % 10)
          0, 1, 2, 3, 4, 5, 6: rsel = ~(4'b0001 << ($urandom % 4));
          7: rsel = 4'hF;
          default: rsel = 4'($urandom);
        endcase
        if (($urandom % 5) < 4) rseg = {1'($urandom), ~PATS[$urandom % 16]};
        else rseg = 8'($urandom);
      end while (rsel == cur_sel && rseg == cur_seg);
      rn = (($urandom % 3) == 0) ? int'($urandom_range(4, 11)) : int'($urandom_range(24, 45));
      hold(rsel, rseg, rn);
      if (rn >= 24 && ($urandom % 8) == 0) clr();
    end
    if (cur_sel == 4'hF && cur_seg == 8'hFF) hold(4'hF, 8'h00, 40);
    else hold(4'hF, 8'hFF, 40);
    chk("rand_pattern_err", {31'd0, pattern_err}, {31'd0, m_perr});
    chk("rand_sel_err", {31'd0, sel_err}, {31'd0, m_serr});
    chk("frames_outstanding", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
